// File: rtl/actctl_pkg.sv
// Shared constants, frame layout and FSM states for the
// actuator-controller SPI front end.
package actctl_pkg;

    localparam int FRAME_BITS  = 32;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 6;

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] ERR_ADDR  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HELD,
        ST_COMMIT,
        ST_RDCAP
    } state_e;

    typedef struct packed {
        logic [7:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input,
// with single-cycle rise/fall pulses on the synced value.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // next synchroniser contents and previous synced sample
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // synchroniser chain and history flop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI slave frame receiver: deserialises 32-bit frames, commits on
// latch_data_n fall. Optional error counter: ACTCTL_FRAME_ERR_EN.
module spi_frame_receiver
    import actctl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    output logic              miso_oe_n,
    input  logic              latch_data_n,
    input  logic              enable_n,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata
`ifdef ACTCTL_FRAME_ERR_EN
   ,output logic              frame_err
`endif
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic ss_s, ss_rise, ss_fall;
    logic latch_s, latch_rise, latch_fall;
    logic enable_s, enable_rise, enable_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clock(clock), .reset_n(reset_n), .din(sclk),
        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clock(clock), .reset_n(reset_n), .din(mosi),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clock(clock), .reset_n(reset_n), .din(ss_n),
        .level(ss_s), .rise(ss_rise), .fall(ss_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_latch (
        .clock(clock), .reset_n(reset_n), .din(latch_data_n),
        .level(latch_s), .rise(latch_rise), .fall(latch_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_enable (
        .clock(clock), .reset_n(reset_n), .din(enable_n),
        .level(enable_s), .rise(enable_rise), .fall(enable_fall));

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [31:0]        rx_shift_q, rx_shift_d;
    logic [31:0]        tx_shift_q, tx_shift_d;
    frame_t             frame_q, frame_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rd_sel;
    logic               err_inc;

`ifdef ACTCTL_FRAME_ERR_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       frame_err_q, frame_err_d;

    // error counter saturates; pulse only on a real increment
    always_comb begin
        err_cnt_d   = err_cnt_q;
        frame_err_d = 1'b0;
        if (err_inc && err_cnt_q != 8'hFF) begin
            err_cnt_d   = err_cnt_q + 8'd1;
            frame_err_d = 1'b1;
        end
    end

    // error counter state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q   <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rd_sel    = (addr_q == ERR_ADDR) ? {8'h00, err_cnt_q} : reg_rdata;
    assign frame_err = frame_err_q;

    logic unused_sigs;
    assign unused_sigs = ^{sclk_s, mosi_rise, mosi_fall, latch_s, latch_rise,
                           enable_rise, enable_fall};
`else
    assign rd_sel = reg_rdata;

    logic unused_sigs;
    assign unused_sigs = ^{sclk_s, mosi_rise, mosi_fall, latch_s, latch_rise,
                           enable_rise, enable_fall, err_inc};
`endif

    // frame FSM: shifting, holding, commit decode and read capture
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        frame_d    = frame_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_inc    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    if (bit_cnt_q == FRAME_CNT) begin
                        state_d = ST_HELD;
                        frame_d = frame_t'(rx_shift_q);
                    end else begin
                        state_d = ST_IDLE;
                        err_inc = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[30:0], mosi_s};
                        if (bit_cnt_q != CNT_MAX) begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_shift_d = {tx_shift_q[30:0], 1'b0};
                    end
                end
            end
            ST_HELD: begin
                if (ss_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end else if (latch_fall) begin
                    if (!enable_s) begin
                        state_d = ST_COMMIT;
                        if (frame_q.cmd == CMD_WRITE) begin
                            wr_en_d = 1'b1;
                            addr_d  = frame_q.addr;
                            wdata_d = frame_q.data;
                        end else if (frame_q.cmd == CMD_READ) begin
                            rd_en_d = 1'b1;
                            addr_d  = frame_q.addr;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                if (frame_q.cmd == CMD_READ) begin
                    state_d = ST_RDCAP;
                end else begin
                    state_d = ST_IDLE;
                    err_inc = (frame_q.cmd != CMD_WRITE);
                end
            end
            ST_RDCAP: begin
                tx_shift_d = {16'h0000, rd_sel};
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, shifters and register-port state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            frame_q    <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            frame_q    <= frame_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign miso      = tx_shift_q[31];
    assign miso_oe_n = ss_s;
    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_en_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: directed scenarios
// plus randomized frames against a transaction-level model.
module tb_spi_frame_receiver;

    localparam int HALF = 6;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        ss_n = 1'b1;
    logic        latch_data_n = 1'b1;
    logic        enable_n = 1'b0;
    logic        miso, miso_oe_n, reg_wr_en, reg_rd_en;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata;
`ifdef ACTCTL_FRAME_ERR_EN
    logic        frame_err;
`endif

    logic [15:0] tb_regs [256];
    int checks = 0;
    int failures = 0;

    logic [23:0] wr_log[$];
    logic [7:0]  rd_log[$];
    logic [23:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int both_cnt = 0;
    int err_pulses = 0;
    int exp_pulses = 0;

    logic [31:0] exp_tx = 32'h0;
    logic [31:0] held_word = 32'h0;
    bit          held_valid = 1'b0;
    int          exp_err = 0;

    always #5 clock = ~clock;

    assign reg_rdata = tb_regs[reg_addr];

    spi_frame_receiver dut (
        .clock(clock), .reset_n(reset_n), .sclk(sclk), .mosi(mosi),
        .ss_n(ss_n), .miso(miso), .miso_oe_n(miso_oe_n),
        .latch_data_n(latch_data_n), .enable_n(enable_n),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
`ifdef ACTCTL_FRAME_ERR_EN
       ,.frame_err(frame_err)
`endif
    );

    always @(negedge clock) begin
        if (reg_wr_en) wr_log.push_back({reg_addr, reg_wdata});
        if (reg_rd_en) rd_log.push_back(reg_addr);
        if (reg_wr_en && reg_rd_en) both_cnt++;
`ifdef ACTCTL_FRAME_ERR_EN
        if (frame_err) err_pulses++;
`endif
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        clk(HALF);
        m = miso;
        sclk = 1'b1;
        clk(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [31:0] w, input int nbits,
                             output logic [31:0] cap);
        logic b, m;
        cap = 32'h0;
        ss_n = 1'b0;
        clk(2 * HALF);
        for (int i = 0; i < nbits; i++) begin
            b = (i < 32) ? w[31 - i] : 1'($urandom_range(0, 1));
            spi_bit(b, m);
            if (i < 32) cap = {cap[30:0], m};
        end
        clk(HALF);
        ss_n = 1'b1;
        clk(2 * HALF);
    endtask

    task automatic model_err();
        if (exp_err < 255) begin
            exp_err++;
            exp_pulses++;
        end
    endtask

    // miso sees the current transmit word MSB first; each bit clocks a zero in
    task automatic model_frame(input logic [31:0] w, input int nbits,
                               output logic [31:0] es);
        es = (nbits >= 32) ? exp_tx : (exp_tx >> (32 - nbits));
        exp_tx = (nbits >= 32) ? 32'h0 : (exp_tx << nbits);
        if (nbits == 32) begin
            held_word = w;
            held_valid = 1'b1;
        end else begin
            held_valid = 1'b0;
            model_err();
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [7:0] a);
`ifdef ACTCTL_FRAME_ERR_EN
        if (a == 8'hFF) return {8'h00, 8'(exp_err)};
`endif
        return tb_regs[a];
    endfunction

    task automatic model_latch();
        logic [7:0] c, a;
        if (held_valid) begin
            held_valid = 1'b0;
            if (!enable_n) begin
                c = held_word[31:24];
                a = held_word[23:16];
                if (c == 8'h02) begin
                    exp_wr.push_back(held_word[23:0]);
                end else if (c == 8'h01) begin
                    exp_rd.push_back(a);
                    exp_tx = {16'h0000, model_rd(a)};
                end else begin
                    model_err();
                end
            end
        end
    endtask

    task automatic xfer(input logic [31:0] w, input int nbits,
                        output logic [31:0] cap, output logic [31:0] es);
        model_frame(w, nbits, es);
        spi_frame(w, nbits, cap);
    endtask

    task automatic commit();
        model_latch();
        latch_data_n = 1'b0;
        clk(4);
        latch_data_n = 1'b1;
        clk(10);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        exp_wr.delete();
        exp_rd.delete();
    endtask

    task automatic test_reset();
        clk(3);
        checks++;
        if (miso !== 1'b0 || miso_oe_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_pins got miso=%b oe_n=%b exp 0/1", miso, miso_oe_n);
        end
        checks++;
        if (reg_wr_en !== 1'b0 || reg_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes got wr=%b rd=%b exp 0/0", reg_wr_en, reg_rd_en);
        end
        checks++;
        if (reg_addr !== 8'h00 || reg_wdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_regs got addr=%h wdata=%h exp 00/0000", reg_addr, reg_wdata);
        end
        reset_n = 1'b1;
        clk(4);
    endtask

    task automatic test_write();
        logic [31:0] cap, es;
        clear_logs();
        xfer(32'h02020008, 32, cap, es);
        checks++;
        if (cap !== 32'h0) begin
            failures++;
            $display("FAIL write_miso got=%h exp=00000000", cap);
        end
        commit();
        checks++;
        if (wr_log.size() != 1 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL write_count got wr=%0d rd=%0d exp 1/0", wr_log.size(), rd_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== 24'h020008) begin
                failures++;
                $display("FAIL write_data got=%h exp=020008", wr_log[0]);
            end
        end
        checks++;
        if (reg_addr !== 8'h02 || reg_wdata !== 16'h0008) begin
            failures++;
            $display("FAIL write_hold got addr=%h wdata=%h exp 02/0008", reg_addr, reg_wdata);
        end
    endtask

    task automatic test_read();
        logic [31:0] cap, es;
        clear_logs();
        tb_regs[8'h04] = 16'h000F;
        xfer(32'h01040000, 32, cap, es);
        commit();
        checks++;
        if (rd_log.size() != 1 || wr_log.size() != 0) begin
            failures++;
            $display("FAIL read_count got rd=%0d wr=%0d exp 1/0", rd_log.size(), wr_log.size());
        end else begin
            checks++;
            if (rd_log[0] !== 8'h04) begin
                failures++;
                $display("FAIL read_addr got=%h exp=04", rd_log[0]);
            end
        end
        xfer(32'h00000000, 32, cap, es);
        checks++;
        if (cap !== 32'h0000000F) begin
            failures++;
            $display("FAIL read_miso got=%h exp=0000000f", cap);
        end
    endtask

    task automatic test_short();
        logic [31:0] cap, es;
        clear_logs();
        xfer(32'h02030055, 20, cap, es);
        commit();
        checks++;
        if (wr_log.size() != 0 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL short_strobe got wr=%0d rd=%0d exp 0/0", wr_log.size(), rd_log.size());
        end
`ifdef ACTCTL_FRAME_ERR_EN
        xfer(32'h01FF0000, 32, cap, es);
        commit();
        xfer(32'h00000000, 32, cap, es);
        checks++;
        if (cap !== 32'h00000001) begin
            failures++;
            $display("FAIL short_errcnt got=%h exp=00000001", cap);
        end
`endif
    endtask

    task automatic test_enable();
        logic [31:0] cap, es;
        clear_logs();
        enable_n = 1'b1;
        xfer(32'h02060080, 32, cap, es);
        commit();
        checks++;
        if (wr_log.size() != 0 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL enable_block got wr=%0d rd=%0d exp 0/0", wr_log.size(), rd_log.size());
        end
        enable_n = 1'b0;
        xfer(32'h02060080, 32, cap, es);
        commit();
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== 24'h060080) begin
            failures++;
            $display("FAIL enable_write got n=%0d data=%h exp 1/060080",
                     wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 24'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic m;
        clear_logs();
        ss_n = 1'b0;
        clk(2 * HALF);
        for (int i = 0; i < 16; i++) spi_bit(1'($urandom_range(0, 1)), m);
        reset_n = 1'b0;
        clk(2);
        checks++;
        if (miso !== 1'b0 || miso_oe_n !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pins got miso=%b oe_n=%b exp 0/1", miso, miso_oe_n);
        end
        ss_n = 1'b1;
        clk(4);
        reset_n = 1'b1;
        exp_tx = 32'h0;
        held_valid = 1'b0;
        exp_err = 0;
        clk(4);
        commit();
        checks++;
        if (wr_log.size() != 0 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL midreset_strobe got wr=%0d rd=%0d exp 0/0", wr_log.size(), rd_log.size());
        end
        checks++;
        if (miso !== 1'b0 || miso_oe_n !== 1'b1) begin
            failures++;
            $display("FAIL midreset_after got miso=%b oe_n=%b exp 0/1", miso, miso_oe_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cap, es;
        clear_logs();
        xfer(32'h02080001, 32, cap, es);
        xfer(32'h020900F0, 32, cap, es);
        commit();
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== 24'h0900F0) begin
            failures++;
            $display("FAIL b2b_write got n=%0d data=%h exp 1/0900f0",
                     wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 24'h0);
        end
    endtask

    task automatic test_random();
        logic [31:0] w, cap, es;
        logic [7:0]  c;
        int          nbits, sel;
        bit          do_latch;
        for (int it = 0; it < 40; it++) begin
            clear_logs();
            sel = $urandom_range(0, 9);
            c = (sel < 4) ? 8'h02 : (sel < 8) ? 8'h01 : 8'($urandom);
            w = {c, 8'($urandom), 16'($urandom)};
            sel = $urandom_range(0, 9);
            nbits = (sel == 0) ? $urandom_range(1, 31) : (sel == 1) ? 33 : 32;
            enable_n = ($urandom_range(0, 5) == 0);
            do_latch = ($urandom_range(0, 4) != 0);
            xfer(w, nbits, cap, es);
            checks++;
            if (cap !== es) begin
                failures++;
                $display("FAIL rand_miso it=%0d got=%h exp=%h", it, cap, es);
            end
            if (do_latch) commit();
            checks++;
            if (wr_log.size() != exp_wr.size() || rd_log.size() != exp_rd.size()) begin
                failures++;
                $display("FAIL rand_count it=%0d got wr=%0d rd=%0d exp %0d/%0d", it,
                         wr_log.size(), rd_log.size(), exp_wr.size(), exp_rd.size());
            end else begin
                foreach (exp_wr[k]) begin
                    checks++;
                    if (wr_log[k] !== exp_wr[k]) begin
                        failures++;
                        $display("FAIL rand_wr it=%0d got=%h exp=%h", it, wr_log[k], exp_wr[k]);
                    end
                end
                foreach (exp_rd[k]) begin
                    checks++;
                    if (rd_log[k] !== exp_rd[k]) begin
                        failures++;
                        $display("FAIL rand_rd it=%0d got=%h exp=%h", it, rd_log[k], exp_rd[k]);
                    end
                end
            end
        end
        enable_n = 1'b0;
    endtask

    task automatic test_final();
        checks++;
        if (both_cnt != 0) begin
            failures++;
            $display("FAIL strobe_overlap got=%0d exp=0", both_cnt);
        end
`ifdef ACTCTL_FRAME_ERR_EN
        checks++;
        if (err_pulses != exp_pulses) begin
            failures++;
            $display("FAIL err_pulses got=%0d exp=%0d", err_pulses, exp_pulses);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_regs[i] = 16'($urandom);
        test_reset();
        test_write();
        test_read();
        test_short();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_final();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
